// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO front-end for a dualRam: drives the RAM pins directly and hides the
// RAM's one-cycle registered read behind a single output holding register.
module ram_fifo_ctrl #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [D_WIDTH-1:0] wr_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [D_WIDTH-1:0] rd_data,
    output logic [A_WIDTH:0]   fill,
    output logic               ram_cs_n,
    output logic               ram_we,
    output logic               ram_oe,
    output logic [A_WIDTH-1:0] ram_waddr,
    output logic [A_WIDTH-1:0] ram_raddr,
    output logic [D_WIDTH-1:0] ram_d,
    input  logic [D_WIDTH-1:0] ram_q
);

    localparam int DEPTH = 1 << A_WIDTH;
    localparam logic [A_WIDTH:0] FULL_CNT = DEPTH[A_WIDTH:0];

    typedef enum logic {
        IDLE = 1'b0,
        CAPT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [A_WIDTH-1:0]   wptr_q, wptr_d;
    logic [A_WIDTH-1:0]   rptr_q, rptr_d;
    logic [A_WIDTH:0]     count_q, count_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [D_WIDTH-1:0]   rd_data_q, rd_data_d;

    logic                 wr_ready_s;
    logic                 wr_fire_s;
    logic                 rd_go_s;
    logic                 ram_oe_s;

    // Handshake and RAM-issue decisions; count is sampled before this cycle's write
    always_comb begin
        wr_ready_s = rst_n & (count_q != FULL_CNT) & (state_q == IDLE);
        wr_fire_s  = wr_valid & wr_ready_s & ~clr;
        rd_go_s    = (state_q == IDLE) & (count_q != {(A_WIDTH+1){1'b0}})
                   & (~rd_valid_q | rd_ready) & ~clr;
        ram_oe_s   = rd_go_s | (state_q == CAPT);
    end

    // Next-state for pointers, occupancy, capture FSM and the output word
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (clr) begin
            state_d    = IDLE;
            wptr_d     = {A_WIDTH{1'b0}};
            rptr_d     = {A_WIDTH{1'b0}};
            count_d    = {(A_WIDTH+1){1'b0}};
            rd_valid_d = 1'b0;
        end else begin
            wptr_d  = wptr_q + {{(A_WIDTH-1){1'b0}}, wr_fire_s};
            rptr_d  = rptr_q + {{(A_WIDTH-1){1'b0}}, rd_go_s};
            count_d = count_q + {{A_WIDTH{1'b0}}, wr_fire_s}
                              - {{A_WIDTH{1'b0}}, rd_go_s};
            case (state_q)
                IDLE: begin
                    if (rd_go_s) begin
                        state_d = CAPT;
                    end else begin
                        state_d = IDLE;
                    end
                    if (rd_valid_q && rd_ready) begin
                        rd_valid_d = 1'b0;
                    end else begin
                        rd_valid_d = rd_valid_q;
                    end
                end
                // RAM output is driven this cycle (oe=1, we=0)
                CAPT: begin
                    state_d    = IDLE;
                    rd_valid_d = 1'b1;
                    rd_data_d  = ram_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wptr_q     <= {A_WIDTH{1'b0}};
            rptr_q     <= {A_WIDTH{1'b0}};
            count_q    <= {(A_WIDTH+1){1'b0}};
            rd_valid_q <= 1'b0;
            rd_data_q  <= {D_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign wr_ready  = wr_ready_s;
    assign ram_we    = wr_fire_s;
    assign ram_oe    = ram_oe_s;
    assign ram_cs_n  = ~(wr_fire_s | ram_oe_s);
    assign ram_waddr = wptr_q;
    assign ram_raddr = rptr_q;
    assign ram_d     = wr_data;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign fill      = count_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl (A_WIDTH=2) with a behavioural dualRam, a cycle model of the
// controller's visible pins and a data scoreboard.
module tb_ram_fifo_ctrl;

    localparam int DW = 16;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [AW:0]   fill;
    logic          ram_cs_n;
    logic          ram_we;
    logic          ram_oe;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_q;

    ram_fifo_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .fill(fill),
        .ram_cs_n(ram_cs_n), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
        .ram_d(ram_d), .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dualRam behaviour: registered read, output only while oe=1 and we=0
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] data_reg;
    always @(posedge clk) begin
        if (!ram_cs_n) begin
            if (ram_we) mem[ram_waddr] <= ram_d;
            if (ram_oe) data_reg <= mem[ram_raddr];
        end
    end
    assign ram_q = (ram_oe && !ram_we) ? data_reg : 16'h0000;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // reference model of the controller as seen from its pins
    logic          m_capt;
    int            m_count;
    logic          m_rv;
    logic [AW-1:0] m_wptr;
    logic [AW-1:0] m_rptr;
    logic [DW-1:0] sb[$];

    task automatic model_reset();
        m_capt = 1'b0; m_count = 0; m_rv = 1'b0; m_wptr = '0; m_rptr = '0;
        sb.delete();
    endtask

    // one clock cycle: check pins against the model mid-cycle, then advance both
    task automatic step();
        logic e_wr_ready, e_fire, e_go, e_oe, e_take;
        logic [DW-1:0] e_word;
        #1;
        e_wr_ready = rst_n && !m_capt && (m_count != DEPTH);
        e_fire     = wr_valid && e_wr_ready && !clr;
        e_go       = rst_n && !m_capt && (m_count != 0) && (!m_rv || rd_ready) && !clr;
        e_oe       = e_go || m_capt;
        e_take     = m_rv && rd_ready;
        check_eq("wr_ready", {31'd0, wr_ready}, {31'd0, e_wr_ready});
        check_eq("ram_we",   {31'd0, ram_we},   {31'd0, e_fire});
        check_eq("ram_oe",   {31'd0, ram_oe},   {31'd0, e_oe});
        check_eq("ram_cs_n", {31'd0, ram_cs_n}, {31'd0, !(e_fire || e_oe)});
        check_eq("rd_valid", {31'd0, rd_valid}, {31'd0, m_rv});
        check_eq("fill",     {29'd0, fill},     m_count);
        if (e_fire) check_eq("ram_waddr", {30'd0, ram_waddr}, {30'd0, m_wptr});
        if (e_go)   check_eq("ram_raddr", {30'd0, ram_raddr}, {30'd0, m_rptr});
        if (e_fire) check_eq("ram_d", {16'd0, ram_d}, {16'd0, wr_data});
        if (e_take && !clr) begin
            check_eq("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e_word = sb.pop_front();
                check_eq("rd_data", {16'd0, rd_data}, {16'd0, e_word});
            end
        end
        if (e_fire) sb.push_back(wr_data);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (clr) begin
            model_reset();
        end else begin
            if (m_capt) m_rv = 1'b1;
            else if (e_take) m_rv = 1'b0;
            m_count = m_count + int'(e_fire) - int'(e_go);
            if (e_fire) m_wptr = m_wptr + 2'd1;
            if (e_go) m_rptr = m_rptr + 2'd1;
            m_capt = e_go;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; wr_valid = 1'b1; wr_data = 16'hBEEF; rd_ready = 1'b0;
        model_reset();
        // reset held with a write offered: nothing may reach the RAM
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1; wr_valid = 1'b0;
        step();

        // first-word latency: write in cycle 0, word visible in cycle 3
        rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 16'h1234;
        #1;
        check_eq("lat_c0_we", {31'd0, ram_we}, 32'd1);
        check_eq("lat_c0_waddr", {30'd0, ram_waddr}, 32'd0);
        step();
        wr_valid = 1'b0;
        #1;
        check_eq("lat_c1_oe", {31'd0, ram_oe}, 32'd1);
        check_eq("lat_c1_raddr", {30'd0, ram_raddr}, 32'd0);
        step();
        check_eq("lat_c2_oe", {31'd0, ram_oe}, 32'd1);
        check_eq("lat_c2_rdv", {31'd0, rd_valid}, 32'd0);
        step();
        check_eq("lat_c3_rdv", {31'd0, rd_valid}, 32'd1);
        check_eq("lat_c3_data", {16'd0, rd_data}, 32'h1234);
        step();

        // fill with consumer stalled: 4 in RAM + 1 held, 6th word stalls
        rd_ready = 1'b0;
        for (int w = 1; w <= 6; ) begin
            wr_valid = 1'b1; wr_data = DW'(w);
            #1;
            if (wr_ready) w++;
            step();
            if (n_checks > 5000) break;
            if (fill == 3'd4 && w == 6) break;
        end
        wr_valid = 1'b1; wr_data = 16'h0006;
        for (int i = 0; i < 3; i++) step();
        check_eq("full_fill", {29'd0, fill}, 32'd4);
        check_eq("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        check_eq("full_held", {16'd0, rd_data}, 32'h0001);

        // drain: one word every two cycles, read address wraps 3->0
        wr_valid = 1'b0; rd_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            #1;
            check_eq("drain_rdv", {31'd0, rd_valid}, {31'd0, (i <= 8) && (i % 2 == 0)});
            if (i <= 8 && i % 2 == 0) check_eq("drain_word", {16'd0, rd_data}, i / 2 + 1);
            if (i <= 6 && i % 2 == 0) check_eq("drain_raddr", {30'd0, ram_raddr}, (2 + i / 2) % 4);
            step();
        end
        check_eq("drain_empty", {29'd0, fill}, 32'd0);

        // producer always offering while consumer always ready
        wr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 16'hA000 + DW'(i);
            step();
        end

        // bring to full, start one capture, then flush during that capture
        rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_data = 16'hC000 + DW'(i);
            step();
        end
        wr_valid = 1'b0; rd_ready = 1'b1;
        step();
        rd_ready = 1'b0; clr = 1'b1;
        #1;
        check_eq("clr_in_capt", {31'd0, ram_oe && !ram_we}, 32'd1);
        check_eq("clr_fill3", {29'd0, fill}, 32'd3);
        step();
        clr = 1'b0;
        #1;
        check_eq("clr_fill", {29'd0, fill}, 32'd0);
        check_eq("clr_rdv", {31'd0, rd_valid}, 32'd0);
        check_eq("clr_idle", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1'b1; wr_data = 16'h5A5A;
        #1;
        check_eq("clr_waddr", {30'd0, ram_waddr}, 32'd0);
        step();
        wr_valid = 1'b0; rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // asynchronous reset in the middle of traffic
        wr_valid = 1'b1; wr_data = 16'h7777;
        step(); step();
        rst_n = 1'b0;
        #1;
        check_eq("arst_fill", {29'd0, fill}, 32'd0);
        check_eq("arst_cs_n", {31'd0, ram_cs_n}, 32'd1);
        check_eq("arst_rdv", {31'd0, rd_valid}, 32'd0);
        model_reset();
        step();
        rst_n = 1'b1; wr_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
